lift_car_ctrl: RTL and testbench

//  Parametrised single-car lift controller; N_FLOORS, travel time, door timing and idle-park floor are set per instance.

---
 rtl/lift_car_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_lift_car_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lift_car_ctrl.sv
// Single-car lift controller: latches car/hall calls and serves them with a
// collective (SCAN) policy, timed doors, emergency hold and idle parking.
module lift_car_ctrl #(
  parameter int N_FLOORS     = 6,
  parameter int TRAVEL_CYC   = 50,
  parameter int DOOR_CYC     = 100,
  parameter int CLOSE_CYC    = 20,
  parameter int IDLE_TIMEOUT = 500,
  parameter int PARK_FLOOR   = 0,
  localparam int FLOOR_W     = $clog2(N_FLOORS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                emergency,
  input  logic [N_FLOORS-1:0] car_call,
  input  logic [N_FLOORS-2:0] hall_up,
  input  logic [N_FLOORS-2:0] hall_dn,
  output logic                move_up,
  output logic                move_down,
  output logic                open_door,
  output logic                close_door,
  output logic                stop,
  output logic [FLOOR_W-1:0]  lcd,
  output logic [N_FLOORS-1:0] led_car,
  output logic [N_FLOORS-2:0] led_hall_up,
  output logic [N_FLOORS-2:0] led_hall_dn
);

  localparam int CNT_MAX = (TRAVEL_CYC > DOOR_CYC)
                         ? ((TRAVEL_CYC > CLOSE_CYC) ? TRAVEL_CYC : CLOSE_CYC)
                         : ((DOOR_CYC > CLOSE_CYC) ? DOOR_CYC : CLOSE_CYC);
  localparam int CNT_W  = $clog2(CNT_MAX + 1);
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]    TRAVEL_LAST = CNT_W'(TRAVEL_CYC - 1);
  localparam logic [CNT_W-1:0]    DOOR_LAST   = CNT_W'(DOOR_CYC - 1);
  localparam logic [CNT_W-1:0]    CLOSE_LAST  = CNT_W'(CLOSE_CYC - 1);
  localparam logic [IDLE_W-1:0]   IDLE_LAST   = IDLE_W'(IDLE_TIMEOUT - 1);
  localparam logic [N_FLOORS-1:0] ONE_HOT0    = N_FLOORS'(1);
  localparam logic [N_FLOORS-1:0] PARK_SEL    = ONE_HOT0 << PARK_FLOOR;

  typedef enum logic [2:0] {
    S_IDLE, S_MOVE_UP, S_MOVE_DN, S_DOOR_OPEN, S_DOOR_CLOSE, S_EMERG
  } state_t;

  state_t              state_reg, state_next;
  logic [FLOOR_W-1:0]  floor_reg, floor_next, nf;
  logic                dir_reg, dir_next;  // 1 = up
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [IDLE_W-1:0]   idle_reg, idle_next;
  logic [N_FLOORS-1:0] car_reg, car_next;
  logic [N_FLOORS-2:0] up_reg, up_next, dn_reg, dn_next;
  logic                emreq_reg, emreq_next;

  logic [N_FLOORS-1:0] up_v, dn_v, all_v, in_all, cur_sel, door_sel, msk, clr_car;
  logic [N_FLOORS-2:0] clr_up, clr_dn;
  logic                enter_door, hold_door, park, mask_in;

  // Hall calls re-indexed by floor so every vector shares one floor index.
  assign up_v    = {1'b0, up_reg};
  assign dn_v    = {dn_reg, 1'b0};
  assign all_v   = car_reg | up_v | dn_v;
  assign in_all  = car_call | {1'b0, hall_up} | {hall_dn, 1'b0};
  assign cur_sel = ONE_HOT0 << floor_reg;

  function automatic logic beyond(input logic [N_FLOORS-1:0] v,
                                  input logic [FLOOR_W-1:0] f, input logic up);
    beyond = 1'b0;
    for (int i = 0; i < N_FLOORS; i++)
      if ((up && i > int'(f)) || (!up && i < int'(f))) beyond = beyond | v[i];
  endfunction

  function automatic logic stop_at(input logic [FLOOR_W-1:0] f, input logic up);
    stop_at = car_reg[f] | (up ? up_v[f] : dn_v[f]) | (all_v[f] & !beyond(all_v, f, up));
  endfunction

  always_comb begin
    state_next = state_reg;
    floor_next = floor_reg;
    dir_next   = dir_reg;
    cnt_next   = cnt_reg;
    idle_next  = '0;
    emreq_next = emreq_reg;
    nf         = floor_reg;
    enter_door = 1'b0;
    hold_door  = 1'b0;
    park       = 1'b0;
    mask_in    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        cnt_next = '0;
        if (emergency) begin
          state_next = S_EMERG;
        end else if (stop_at(floor_reg, dir_reg)) begin
          state_next = S_DOOR_OPEN;
          enter_door = 1'b1;
        end else if (beyond(all_v, floor_reg, dir_reg)) begin
          state_next = dir_reg ? S_MOVE_UP : S_MOVE_DN;
        end else if (beyond(all_v, floor_reg, !dir_reg)) begin
          dir_next   = !dir_reg;
          state_next = dir_reg ? S_MOVE_DN : S_MOVE_UP;
        end else if (in_all == '0) begin
          if (idle_reg == IDLE_LAST) park = (floor_reg != FLOOR_W'(PARK_FLOOR));
          else idle_next = idle_reg + IDLE_W'(1);
        end
      end
      S_MOVE_UP, S_MOVE_DN: begin
        if (emergency) emreq_next = 1'b1;
        if (cnt_reg == TRAVEL_LAST) begin
          cnt_next   = '0;
          nf         = (state_reg == S_MOVE_UP) ? floor_reg + FLOOR_W'(1) : floor_reg - FLOOR_W'(1);
          floor_next = nf;
          if (emreq_reg || emergency) begin
            state_next = S_EMERG;
            emreq_next = 1'b0;
          end else if (stop_at(nf, dir_reg)) begin
            state_next = S_DOOR_OPEN;
            enter_door = 1'b1;
          end else if (!beyond(all_v, nf, dir_reg)) begin
            state_next = S_IDLE;
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      S_DOOR_OPEN: begin
        if (emergency) begin
          state_next = S_EMERG;
        end else begin
          hold_door = 1'b1;
          if (in_all[floor_reg]) begin
            cnt_next = '0;
            mask_in  = 1'b1;
          end else if (cnt_reg == DOOR_LAST) begin
            state_next = S_DOOR_CLOSE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
      end
      S_DOOR_CLOSE: begin
        if (emergency) begin
          state_next = S_EMERG;
        end else if (in_all[floor_reg]) begin
          state_next = S_DOOR_OPEN;
          enter_door = 1'b1;
        end else if (cnt_reg == CLOSE_LAST) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      S_EMERG: begin
        cnt_next = '0;
        if (!emergency) state_next = S_DOOR_CLOSE;
      end
      default: state_next = S_IDLE;
    endcase

    // Serve the calls at the door floor; turn round once nothing lies ahead.
    door_sel = ONE_HOT0 << floor_next;
    clr_car  = '0;
    clr_up   = '0;
    clr_dn   = '0;
    if (enter_door || hold_door) begin
      clr_car = door_sel;
      if (dir_reg) clr_up = door_sel[N_FLOORS-2:0];
      else clr_dn = door_sel[N_FLOORS-1:1];
    end
    if (enter_door) begin
      cnt_next = '0;
      if (!beyond(all_v, floor_next, dir_reg)) begin
        dir_next = !dir_reg;
        clr_up   = door_sel[N_FLOORS-2:0];
        clr_dn   = door_sel[N_FLOORS-1:1];
      end
    end

    msk      = mask_in ? cur_sel : '0;
    car_next = (car_reg & ~clr_car) | (car_call & ~msk) | (park ? PARK_SEL : '0);
    up_next  = (up_reg & ~clr_up) | (hall_up & ~msk[N_FLOORS-2:0]);
    dn_next  = (dn_reg & ~clr_dn) | (hall_dn & ~msk[N_FLOORS-1:1]);
    if (state_next == S_EMERG) begin
      car_next = '0;
      up_next  = '0;
      dn_next  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      floor_reg <= '0;
      dir_reg   <= 1'b1;
      cnt_reg   <= '0;
      idle_reg  <= '0;
      car_reg   <= '0;
      up_reg    <= '0;
      dn_reg    <= '0;
      emreq_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      floor_reg <= floor_next;
      dir_reg   <= dir_next;
      cnt_reg   <= cnt_next;
      idle_reg  <= idle_next;
      car_reg   <= car_next;
      up_reg    <= up_next;
      dn_reg    <= dn_next;
      emreq_reg <= emreq_next;
    end
  end

  assign move_up     = (state_reg == S_MOVE_UP);
  assign move_down   = (state_reg == S_MOVE_DN);
  assign open_door   = (state_reg == S_DOOR_OPEN) || (state_reg == S_EMERG);
  assign close_door  = (state_reg == S_DOOR_CLOSE);
  assign stop        = !(move_up || move_down);
  assign lcd         = floor_reg;
  assign led_car     = car_reg;
  assign led_hall_up = up_reg;
  assign led_hall_dn = dn_reg;

endmodule

// File: tb/tb_lift_car_ctrl.sv
// Directed bench for lift_car_ctrl; door-open floors are scored against a
// queue of expected floors filled as each call is issued.
module tb_lift_car_ctrl;
  localparam int N = 6;
  localparam int T = 4;
  localparam int D = 8;
  localparam int C = 2;
  localparam int IT = 30;
  localparam int PARK = 0;
  localparam int S_UP = 0, S_DN = 1, S_OPEN = 2, S_CLOSE = 3;

  logic         clk = 1'b0, rst = 1'b1, emergency = 1'b0;
  logic [N-1:0] car_call = '0;
  logic [N-2:0] hall_up = '0, hall_dn = '0;
  logic         move_up, move_down, open_door, close_door, stop;
  logic [2:0]   lcd;
  logic [N-1:0] led_car;
  logic [N-2:0] led_hall_up, led_hall_dn;

  int   n_cmp = 0, n_err = 0;
  int   exp_q[$];
  int   obs_log[64];
  int   obs_n = 0;
  int   rd = 0;
  logic prev_open = 1'b0;

  lift_car_ctrl #(.N_FLOORS(N), .TRAVEL_CYC(T), .DOOR_CYC(D), .CLOSE_CYC(C),
                  .IDLE_TIMEOUT(IT), .PARK_FLOOR(PARK)) dut (
    .clk(clk), .rst(rst), .emergency(emergency), .car_call(car_call),
    .hall_up(hall_up), .hall_dn(hall_dn), .move_up(move_up), .move_down(move_down),
    .open_door(open_door), .close_door(close_door), .stop(stop), .lcd(lcd),
    .led_car(led_car), .led_hall_up(led_hall_up), .led_hall_dn(led_hall_dn)
  );

  always #5 clk = ~clk;

  // Log the floor at every rising edge of the door-open command.
  always @(negedge clk) begin
    if (!rst && open_door && !prev_open && obs_n < 64) begin
      obs_log[obs_n] <= int'(lcd);
      obs_n <= obs_n + 1;
    end
    prev_open <= open_door;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      S_UP:    return move_up;
      S_DN:    return move_down;
      S_OPEN:  return open_door;
      default: return close_door;
    endcase
  endfunction

  task automatic wait_for(input int sel, input string tag);
    int n;
    n = 0;
    while (!sig(sel) && n < 400) begin
      tick();
      n++;
    end
    chk(tag, int'(sig(sel)), 1);
  endtask

  task automatic run_while(input int sel, output int n);
    n = 0;
    while (sig(sel) && n < 400) begin
      n++;
      tick();
    end
  endtask

  task automatic pulse_car(input int f);
    car_call = '0;
    car_call[f] = 1'b1;
    tick();
    car_call = '0;
  endtask

  task automatic drain(input string tag);
    int w;
    int e;
    w = 0;
    while (obs_n < rd + exp_q.size() && w < 400) begin
      tick();
      w++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd < obs_n) chk({tag, "_door_floor"}, obs_log[rd], e);
      else chk({tag, "_door_missing"}, -1, e);
      rd++;
    end
    chk({tag, "_extra_doors"}, obs_n, rd);
  endtask

  initial begin
    int n;
    // Reset state
    tick();
    tick();
    chk("rst_stop", int'(stop), 1);
    chk("rst_lcd", int'(lcd), 0);
    chk("rst_move", int'(move_up | move_down), 0);
    chk("rst_doors", int'(open_door | close_door), 0);
    rst = 1'b0;
    tick();

    // Hall-up call two floors away
    hall_up = 5'b00100;
    tick();
    hall_up = '0;
    exp_q.push_back(2);
    chk("s2_led_up", int'(led_hall_up), 4);
    wait_for(S_UP, "s2_start");
    repeat (4) tick();
    chk("s2_lcd_mid", int'(lcd), 1);
    run_while(S_UP, n);
    chk("s2_move_len", n + 4, 2 * T);
    chk("s2_lcd_arr", int'(lcd), 2);
    chk("s2_led_clr", int'(led_hall_up), 0);
    run_while(S_OPEN, n);
    chk("s2_open_len", n, D);
    run_while(S_CLOSE, n);
    chk("s2_close_len", n, C);
    chk("s2_stop", int'(stop), 1);
    drain("s2");

    // Reset pulse while travelling up
    pulse_car(5);
    chk("s1_led_car", int'(led_car), 32);
    wait_for(S_UP, "s1_start");
    repeat (6) tick();
    chk("s1_moving", int'(move_up), 1);
    rst = 1'b1;
    #2;
    chk("s1_stop", int'(stop), 1);
    chk("s1_move_up", int'(move_up), 0);
    chk("s1_lcd", int'(lcd), 0);
    chk("s1_leds", int'({led_car, led_hall_up, led_hall_dn}), 0);
    rst = 1'b0;
    tick();
    chk("s1_idle", int'(move_up | move_down), 0);

    // Car call to 4; hall-down at 2 registered on the way up
    pulse_car(4);
    exp_q.push_back(4);
    wait_for(S_UP, "s3_start");
    n = 0;
    while (lcd != 3'd1 && n < 100) begin
      tick();
      n++;
    end
    hall_dn = 5'b00010;
    tick();
    hall_dn = '0;
    exp_q.push_back(2);
    chk("s3_led_dn", int'(led_hall_dn), 2);
    wait_for(S_OPEN, "s3_open4");
    chk("s3_lcd4", int'(lcd), 4);
    chk("s3_dn_pending", int'(led_hall_dn), 2);
    run_while(S_OPEN, n);
    run_while(S_CLOSE, n);
    wait_for(S_DN, "s3_down");
    wait_for(S_OPEN, "s3_open2");
    chk("s3_lcd2", int'(lcd), 2);
    chk("s3_dn_clr", int'(led_hall_dn), 0);
    run_while(S_OPEN, n);
    chk("s3_open_len", n, D);

    // Reopen from door closing at floor 2
    chk("s6_closing", int'(close_door), 1);
    exp_q.push_back(2);
    pulse_car(2);
    chk("s6_reopen", int'(open_door), 1);
    run_while(S_OPEN, n);
    chk("s6_open_len", n, D);
    chk("s6_led_car", int'(led_car), 0);
    run_while(S_CLOSE, n);
    chk("s6_close_len", n, C);
    drain("s3");

    // Emergency raised between floors 1 and 2
    pulse_car(1);
    exp_q.push_back(1);
    wait_for(S_OPEN, "s4_open1");
    run_while(S_OPEN, n);
    run_while(S_CLOSE, n);
    pulse_car(3);
    wait_for(S_UP, "s4_up");
    tick();
    emergency = 1'b1;
    exp_q.push_back(2);
    wait_for(S_OPEN, "s4_emerg_open");
    chk("s4_lcd", int'(lcd), 2);
    chk("s4_stop", int'(stop), 1);
    chk("s4_move_up", int'(move_up), 0);
    chk("s4_calls_clr", int'(led_car), 0);
    pulse_car(4);
    chk("s4_call_ignored", int'(led_car), 0);
    chk("s4_hold_open", int'(open_door), 1);
    emergency = 1'b0;
    tick();
    chk("s4_close", int'(close_door), 1);
    chk("s4_open_off", int'(open_door), 0);
    run_while(S_CLOSE, n);
    chk("s4_close_len", n, C);
    tick();
    chk("s4_idle", int'(move_up | move_down), 0);
    drain("s4");

    // Idle at floor 3 until the park call appears
    pulse_car(3);
    exp_q.push_back(3);
    wait_for(S_OPEN, "s5_open3");
    chk("s5_lcd3", int'(lcd), 3);
    run_while(S_OPEN, n);
    run_while(S_CLOSE, n);
    n = 0;
    while (led_car[PARK] !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("s5_park_delay", n, IT);
    chk("s5_led_car", int'(led_car), 1 << PARK);
    exp_q.push_back(PARK);
    wait_for(S_DN, "s5_down");
    wait_for(S_OPEN, "s5_open0");
    chk("s5_lcd0", int'(lcd), PARK);
    run_while(S_OPEN, n);
    run_while(S_CLOSE, n);
    drain("s5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
